// File: rtl/demux_striping.sv
// demux_striping
//   Transmit-side striper for a two-lane link. One word stream arrives on clk_2f.
//   Even words go to lane_0 and odd words go to lane_1. Each even word is held for
//   one edge so that both words of a pair appear on the lanes on the same edge.
//   An even word that has no partner is flushed alone and marked with odd_flush.
//
// Ports
//   clk_2f       in   single clock, all state updates on its rising edge
//   reset_L      in   synchronous active-low reset
//   data_input   in   WIDTH-bit incoming word
//   valid_input  in   data_input is valid this cycle
//   lane_0       out  even-word lane data (registered, holds when valid_0=0)
//   lane_1       out  odd-word lane data (registered, holds when valid_1=0)
//   valid_0      out  lane_0 carries a new word this cycle
//   valid_1      out  lane_1 carries a new word this cycle
//   odd_flush    out  single-cycle pulse: even word sent without a partner

module demux_striping #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_input,
    input  logic             valid_input,
    output logic [WIDTH-1:0] lane_0,
    output logic [WIDTH-1:0] lane_1,
    output logic             valid_0,
    output logic             valid_1,
    output logic             odd_flush
);

    typedef enum logic {
        StEven,    // waiting for the even word of a pair
        StPending  // even word is parked in hold_0_q
    } sel_e;

    sel_e             sel_q;
    logic [WIDTH-1:0] hold_0_q;

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            // A parked even word is dropped here; it is never flushed.
            sel_q     <= StEven;
            hold_0_q  <= '0;
            lane_0    <= '0;
            lane_1    <= '0;
            valid_0   <= 1'b0;
            valid_1   <= 1'b0;
            odd_flush <= 1'b0;
        end else begin
            // Pulses default low so they never stretch beyond one cycle.
            valid_0   <= 1'b0;
            valid_1   <= 1'b0;
            odd_flush <= 1'b0;
            unique case (sel_q)
                StEven: begin
                    if (valid_input) begin
                        hold_0_q <= data_input;
                        sel_q    <= StPending;
                    end
                end
                StPending: begin
                    lane_0  <= hold_0_q;
                    valid_0 <= 1'b1;
                    sel_q   <= StEven;
                    if (valid_input) begin
                        lane_1  <= data_input;
                        valid_1 <= 1'b1;
                    end else begin
                        // Stream gap after an even word: send it alone, lane_1 holds.
                        odd_flush <= 1'b1;
                    end
                end
                default: sel_q <= StEven;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_striping.sv
module tb_demux_striping;

    localparam int unsigned WIDTH = 32;

    logic             clk_2f = 1'b0;
    logic             reset_L;
    logic [WIDTH-1:0] data_input;
    logic             valid_input;
    logic [WIDTH-1:0] lane_0;
    logic [WIDTH-1:0] lane_1;
    logic             valid_0;
    logic             valid_1;
    logic             odd_flush;

    demux_striping #(.WIDTH(WIDTH)) dut (
        .clk_2f      (clk_2f),
        .reset_L     (reset_L),
        .data_input  (data_input),
        .valid_input (valid_input),
        .lane_0      (lane_0),
        .lane_1      (lane_1),
        .valid_0     (valid_0),
        .valid_1     (valid_1),
        .odd_flush   (odd_flush)
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic [WIDTH-1:0] l0;
        logic [WIDTH-1:0] l1;
        logic             v0;
        logic             v1;
        logic             fl;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk_2f) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Expected output appears after the next sampling edge.
    task automatic expect_out(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                              input logic v1, input logic fl);
        exp_t e;
        e.l0 = l0; e.l1 = l1; e.v0 = 1'b1; e.v1 = v1; e.fl = fl; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rl, input logic v, input logic [WIDTH-1:0] d);
        reset_L     = rl;
        valid_input = v;
        data_input  = d;
        @(posedge clk_2f);
        #1;
    endtask

    // Monitor: every cycle with any output pulse must match the next scoreboard entry.
    always @(negedge clk_2f) begin
        if (mon_en && (valid_0 || valid_1 || odd_flush)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {valid_0, valid_1, odd_flush, lane_0, lane_1}, '0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_cycle", 128'(cyc), 128'(e.cyc));
                check("out_lanes", {lane_0, lane_1}, {e.l0, e.l1});
                check("out_flags", {valid_0, valid_1, odd_flush}, {e.v0, e.v1, e.fl});
            end
        end
    end

    initial begin
        reset_L     = 1'b0;
        valid_input = 1'b0;
        data_input  = '0;

        // 1. reset held for two edges with valid data driven
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 32'hFFFF_FFFF);
            check("reset_lanes", {lane_0, lane_1}, '0);
            check("reset_flags", {valid_0, valid_1, odd_flush}, '0);
        end
        mon_en = 1'b1;
        step(1'b1, 1'b0, '0);

        // 2. single pair
        step(1'b1, 1'b1, 32'hAAAA_AAAA);
        expect_out(32'hAAAA_AAAA, 32'hEEEE_EEEE, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hEEEE_EEEE);
        step(1'b1, 1'b0, '0);

        // 3. back-to-back stream
        step(1'b1, 1'b1, 32'hAAAA_AAAA);
        expect_out(32'hAAAA_AAAA, 32'hEEEE_EEEE, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hEEEE_EEEE);
        step(1'b1, 1'b1, 32'hCCCC_CCCC);
        expect_out(32'hCCCC_CCCC, 32'hAAAA_AAAA, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hAAAA_AAAA);
        step(1'b1, 1'b1, 32'h1111_1111);
        expect_out(32'h1111_1111, 32'h9999_9999, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h9999_9999);
        step(1'b1, 1'b0, '0);

        // 4. odd end: lane_1 keeps 99999999
        step(1'b1, 1'b1, 32'hCCCC_CCCC);
        expect_out(32'hCCCC_CCCC, 32'h9999_9999, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h5555_5555);
        step(1'b1, 1'b0, '0);

        // 5. reset while an even word is pending
        step(1'b1, 1'b1, 32'h1111_1111);
        step(1'b0, 1'b0, '0);
        check("midreset_lanes", {lane_0, lane_1}, '0);
        check("midreset_flags", {valid_0, valid_1, odd_flush}, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h9999_9999);
        expect_out(32'h9999_9999, 32'h2222_2222, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h2222_2222);
        step(1'b1, 1'b0, '0);

        // 6. gapped input: two flushes, lane_1 stays 22222222
        step(1'b1, 1'b1, 32'hAAAA_AAAA);
        expect_out(32'hAAAA_AAAA, 32'h2222_2222, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h3333_3333);
        step(1'b1, 1'b1, 32'hEEEE_EEEE);
        expect_out(32'hEEEE_EEEE, 32'h2222_2222, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
        check("scoreboard_drained", 128'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
